wb_periodic_timer: RTL

Wishbone B3 slave timer in the on-chip RAM + timer LM32 platform. It sits directly downstream of the LM32 data bus and gives firmware a programmable periodic or one-shot countdown with a level interrupt to the CPU. Firmware uses its timeout count to pace the test programs run on the simulation platform before they trap with the exit system call.

---
 rtl/wb_timer_pkg.sv | 17 +
 rtl/wb_timer_counter.sv | 44 ++++
 rtl/wb_periodic_timer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wb_timer_pkg.sv
// Shared register offsets and bit positions for the Wishbone periodic timer.
// Used by the top and by the bench.
package wb_timer_pkg;

  localparam logic [1:0] TIMER_STATUS   = 2'd0;
  localparam logic [1:0] TIMER_CONTROL  = 2'd1;
  localparam logic [1:0] TIMER_PERIOD   = 2'd2;
  localparam logic [1:0] TIMER_SNAPSHOT = 2'd3;

  localparam int TO_BIT    = 0;
  localparam int RUN_BIT   = 1;
  localparam int ITO_BIT   = 0;
  localparam int CONT_BIT  = 1;
  localparam int START_BIT = 2;
  localparam int STOP_BIT  = 3;

endpackage

// File: rtl/wb_timer_counter.sv
// Down-counter with load, stop, continuous reload and a one-cycle
// expire flag raised while the count sits at 1.
module wb_timer_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             load,
  input  logic             stop,
  input  logic             cont,
  input  logic [WIDTH-1:0] period,
  output logic             run,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  logic reload_ok;

  assign expire    = run && (count == WIDTH'(1));
  assign reload_ok = cont && (period != '0);

  // stop beats load, load beats the natural expiry
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      run   <= 1'b0;
      count <= '0;
    end else if (stop) begin
      run <= 1'b0;
    end else if (load) begin
      run   <= 1'b1;
      count <= period;
    end else if (expire) begin
      if (reload_ok) begin
        count <= period;
      end else begin
        run   <= 1'b0;
        count <= '0;
      end
    end else if (run) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_periodic_timer.sv
// Wishbone B3 periodic/one-shot timer with level interrupt.
// Define WB_TIMER_SNAPSHOT_EN to expose the live counter at offset 3.
module wb_periodic_timer
  import wb_timer_pkg::*;
#(
  parameter int          COUNTER_WIDTH = 32,
  parameter logic [31:0] PERIOD_RESET  = 32'd0
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        irq_o
);

  localparam int W = COUNTER_WIDTH;

  logic         req;
  logic         wr;
  logic         sel_status;
  logic         sel_control;
  logic         sel_period;
  logic         sel_snapshot;
  logic         start;
  logic         stop;
  logic         load;
  logic         to_q;
  logic         ito_q;
  logic         cont_q;
  logic [W-1:0] period_q;
  logic         run;
  logic         expire;
  logic [W-1:0] count;
  logic [31:0]  rdata;
  logic         unused;

  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr  = req & wb_we_i & (wb_sel_i == 4'hF);

  assign sel_status   = (wb_adr_i[3:2] == TIMER_STATUS);
  assign sel_control  = (wb_adr_i[3:2] == TIMER_CONTROL);
  assign sel_period   = (wb_adr_i[3:2] == TIMER_PERIOD);
  assign sel_snapshot = (wb_adr_i[3:2] == TIMER_SNAPSHOT);

  assign start = wr & sel_control & wb_dat_i[START_BIT];
  assign stop  = wr & sel_control & wb_dat_i[STOP_BIT];
  assign load  = start & (period_q != '0);

  assign irq_o    = to_q & ito_q;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign unused   = ^{wb_adr_i[1:0], wb_dat_i, count};

  wb_timer_counter #(
    .WIDTH(W)
  ) u_counter (
    .clk_i  (clk_i),
    .reset_n(reset_n),
    .load   (load),
    .stop   (stop),
    .cont   (cont_q),
    .period (period_q),
    .run    (run),
    .count  (count),
    .expire (expire)
  );

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_status: begin
        rdata[TO_BIT]  = to_q;
        rdata[RUN_BIT] = run;
      end
      sel_control: begin
        rdata[ITO_BIT]  = ito_q;
        rdata[CONT_BIT] = cont_q;
      end
      sel_period: rdata[W-1:0] = period_q;
      sel_snapshot: begin
`ifdef WB_TIMER_SNAPSHOT_EN
        rdata[W-1:0] = count;
`else
        rdata = '0;
`endif
      end
      default: rdata = '0;
    endcase
  end

  // a timeout in the same cycle as a STATUS write keeps TO set
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      to_q     <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      period_q <= PERIOD_RESET[W-1:0];
    end else begin
      wb_ack_o <= req;
      if (req) wb_dat_o <= rdata;
      to_q <= expire | (to_q & ~(wr & sel_status));
      if (wr & sel_control) begin
        ito_q  <= wb_dat_i[ITO_BIT];
        cont_q <= wb_dat_i[CONT_BIT];
      end
      if (wr & sel_period) period_q <= wb_dat_i[W-1:0];
    end
  end

endmodule
